// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU.
// Contents:
//   - OP_* : 4-bit ALU opcodes. The same encoding is used by the decode-side control logic.
//   - alu_state_e : sequencing state of alu_exec.
//   - is_shift_op() : true for the five opcodes that run on the iterative shifter.
package alu_exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_LSL = 4'd1;
    localparam logic [3:0] OP_LSR = 4'd2;
    localparam logic [3:0] OP_CSL = 4'd3;
    localparam logic [3:0] OP_CSR = 4'd4;
    localparam logic [3:0] OP_ASR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return op inside {OP_LSL, OP_LSR, OP_CSL, OP_CSR, OP_ASR};
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit step of the iterative shifter.
// Ports:
//   op      in  4  latched shift opcode (LSL/LSR/CSL/CSR/ASR). Any other opcode passes the value through.
//   value   in  W  current shift register contents.
//   stepped out W  value after a one-bit shift or rotate.
module alu_shift_step
    import alu_exec_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [WORD_WIDTH-1:0] value,
    output logic [WORD_WIDTH-1:0] stepped
);

    always_comb begin
        stepped = value;
        case (op)
            OP_LSL:  stepped = {value[WORD_WIDTH-2:0], 1'b0};
            OP_LSR:  stepped = {1'b0, value[WORD_WIDTH-1:1]};
            OP_CSL:  stepped = {value[WORD_WIDTH-2:0], value[WORD_WIDTH-1]};
            OP_CSR:  stepped = {value[0], value[WORD_WIDTH-1:1]};
            OP_ASR:  stepped = {value[WORD_WIDTH-1], value[WORD_WIDTH-1:1]};
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Add and logic ops complete in one cycle. Shifts and rotates run
// one bit per cycle on a shared single-bit shifter. This block owns the architectural
// carry and overflow flags.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  input handshake for the control word and operands
//   alu_a, alu_b       operands. For shifts, alu_a is the shifted value and alu_b mod W is the amount.
//   alu_ic             carry-in for OP_ADD
//   alu_opcode         ALU opcode (see alu_exec_pkg)
//   store_carry/_overflow  flag write enables; they act only for OP_ADD
//   out_valid/out_ready    output handshake for result
//   result             registered result
//   carry, overflow    architectural flag registers
//   state_dbg          current sequencing state, for observation only
//
// Handshake: a transfer happens on any rising edge where valid && ready are both high.
// A producer holds valid and its data until that edge. ready never depends on valid.
// result and out_valid hold stable while out_valid && !out_ready.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] alu_a,
    input  logic [WORD_WIDTH-1:0] alu_b,
    input  logic                  alu_ic,
    input  logic [3:0]            alu_opcode,
    input  logic                  store_carry,
    input  logic                  store_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  overflow,
    output alu_state_e            state_dbg
);

    localparam int SW = $clog2(WORD_WIDTH);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    alu_state_e            state, state_next;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] stepped;
    logic [WORD_WIDTH-1:0] op_result;
    logic [WORD_WIDTH:0]   sum;
    logic [SW-1:0]         cnt;
    logic [SW-1:0]         amount;
    logic [3:0]            op_q;
    logic                  accept;
    logic                  start_shift;
    logic                  shift_done;
    logic                  load_result;

    assign amount = alu_b[SW-1:0];

    // Output process of the FSM: handshake and sequencing strobes.
    always_comb begin
        in_ready    = !reset && (state == ST_IDLE) && (!out_valid || out_ready);
        accept      = in_valid && in_ready;
        // A shift by zero needs no iteration. It completes like a single-cycle op with result = A.
        start_shift = accept && is_shift_op(alu_opcode) && (amount != '0);
        shift_done  = (state == ST_SHIFT) && (cnt == CNT_ONE);
        load_result = (accept && !start_shift) || shift_done;
        state_dbg   = state;
    end

    // Next-state process.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_shift) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_ONE) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Single-cycle datapath. Undefined opcodes fall through to the B passthrough.
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {{WORD_WIDTH{1'b0}}, alu_ic};
        case (alu_opcode)
            OP_ADD: op_result = sum[WORD_WIDTH-1:0];
            OP_AND: op_result = alu_a & alu_b;
            OP_OR:  op_result = alu_a | alu_b;
            OP_XOR: op_result = alu_a ^ alu_b;
            // Shifts reach this mux only when the amount is zero.
            OP_LSL, OP_LSR, OP_CSL, OP_CSR, OP_ASR: op_result = alu_a;
            default: op_result = alu_b;
        endcase
    end

    alu_shift_step #(.WORD_WIDTH(WORD_WIDTH)) u_shift_step (
        .op      (op_q),
        .value   (shreg),
        .stepped (stepped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            op_q      <= OP_NOP;
        end else begin
            if (start_shift) begin
                shreg <= alu_a;
                cnt   <= amount;
                op_q  <= alu_opcode;
            end else if (state == ST_SHIFT) begin
                shreg <= stepped;
                cnt   <= cnt - CNT_ONE;
            end

            if (accept && !start_shift) result <= op_result;
            else if (shift_done)        result <= stepped;

            // A new result that loads on the drain edge keeps out_valid high.
            if (load_result)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            if (accept && (alu_opcode == OP_ADD)) begin
                if (store_carry)    carry    <= sum[WORD_WIDTH];
                if (store_overflow) overflow <= (alu_a[WORD_WIDTH-1] == alu_b[WORD_WIDTH-1]) &&
                                                (sum[WORD_WIDTH-1] != alu_a[WORD_WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking testbench for alu_exec at W=32.
// It uses directed scenarios plus randomized operations. The randomized operations
// are checked against an arithmetic reference model.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] alu_a = '0;
    logic [W-1:0] alu_b = '0;
    logic         alu_ic = 1'b0;
    logic [3:0]   alu_opcode = OP_NOP;
    logic         store_carry = 1'b0;
    logic         store_overflow = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    alu_state_e   state_dbg;

    int vectors = 0;
    int miscompares = 0;
    logic ref_carry = 1'b0;
    logic ref_overflow = 1'b0;
    logic [W-1:0] exp_q[$];

    alu_exec #(.WORD_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
        .store_carry(store_carry), .store_overflow(store_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .overflow(overflow), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_CSL) || (op == OP_CSR) || (op == OP_ASR);
    endfunction

    function automatic int shift_amount(input logic [W-1:0] b);
        return int'(b % W);
    endfunction

    function automatic logic [W-1:0] model_result(input logic [3:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b, input logic ic);
        logic [W:0] s;
        int n;
        n = shift_amount(b);
        s = {1'b0, a} + {1'b0, b} + (W+1)'(ic);
        case (op)
            OP_ADD: return s[W-1:0];
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_LSL: return a << n;
            OP_LSR: return a >> n;
            OP_CSL: return (a << n) | (a >> (W - n));
            OP_CSR: return (a >> n) | (a << (W - n));
            OP_ASR: return W'($signed(a) >>> n);
            default: return b;
        endcase
    endfunction

    function automatic void model_flags(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic ic,
                                        input logic sc, input logic so);
        logic [W:0] s;
        if (op != OP_ADD) return;
        s = {1'b0, a} + {1'b0, b} + (W+1)'(ic);
        if (sc) ref_carry = s[W];
        if (so) ref_overflow = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [W-1:0] b);
        if (is_shift(op) && shift_amount(b) != 0) return shift_amount(b) + 1;
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ic, input logic sc, input logic so);
        alu_opcode = op; alu_a = a; alu_b = b; alu_ic = ic;
        store_carry = sc; store_overflow = so;
    endtask

    // Issues one op, waits for its result, and returns the result, the cycles from
    // acceptance to out_valid, and whether in_ready rose while the op was in flight.
    // It leaves the result drained (out_ready is expected to be high).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ic, input logic sc, input logic so,
                          output logic [W-1:0] res, output int lat, output bit ready_seen);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin step(); guard++; end
        drive(op, a, b, ic, sc, so);
        in_valid = 1'b1;
        model_flags(op, a, b, ic, sc, so);
        step();
        in_valid = 1'b0;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            lat++;
        end
        res = result;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
        vectors++; if ({carry, overflow} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got c=%b v=%b expected 0 0", carry, overflow); end
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        ref_carry = 1'b0; ref_overflow = 1'b0;
    endtask

    task automatic test_add();
        logic [W-1:0] res; int lat; bit rs;
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, res, lat, rs);
        vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL add_wrap_res: got %h expected 00000000", res); end
        vectors++; if ({carry, overflow} !== 2'b10) begin miscompares++; $display("FAIL add_wrap_flags: got c=%b v=%b expected 1 0", carry, overflow); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d expected 1", lat); end

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b1, res, lat, rs);
        vectors++; if (res !== 32'h8000_0001) begin miscompares++; $display("FAIL add_ovf_res: got %h expected 80000001", res); end
        vectors++; if ({carry, overflow} !== 2'b01) begin miscompares++; $display("FAIL add_ovf_flags: got c=%b v=%b expected 0 1", carry, overflow); end

        // Store bits clear: the same op, then one that would set carry, must leave flags alone.
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== 32'h8000_0001) begin miscompares++; $display("FAIL add_nostore_res: got %h expected 80000001", res); end
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== 32'h1) begin miscompares++; $display("FAIL add_nostore_res2: got %h expected 00000001", res); end
        vectors++; if ({carry, overflow} !== 2'b01) begin miscompares++; $display("FAIL add_nostore_flags: got c=%b v=%b expected 0 1", carry, overflow); end
    endtask

    task automatic test_shift();
        logic [W-1:0] res; logic [W-1:0] a; int lat; bit rs;
        run_op(OP_LSL, 32'h1, 32'd5, 1'b0, 1'b1, 1'b1, res, lat, rs);
        vectors++; if (res !== 32'h20) begin miscompares++; $display("FAIL lsl5_res: got %h expected 00000020", res); end
        vectors++; if (lat !== 6) begin miscompares++; $display("FAIL lsl5_latency: got %0d expected 6", lat); end
        vectors++; if (rs !== 1'b0) begin miscompares++; $display("FAIL lsl5_in_ready: got %b expected 0 while shifting", rs); end
        run_op(OP_CSR, 32'h1, 32'd33, 1'b0, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== 32'h8000_0000) begin miscompares++; $display("FAIL csr33_res: got %h expected 80000000", res); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL csr33_latency: got %0d expected 2", lat); end
        run_op(OP_ASR, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== 32'hF800_0000) begin miscompares++; $display("FAIL asr4_res: got %h expected f8000000", res); end
        run_op(OP_CSL, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== 32'h0000_0003) begin miscompares++; $display("FAIL csl1_res: got %h expected 00000003", res); end
        a = $urandom;
        run_op(OP_LSR, a, 32'd0, 1'b0, 1'b0, 1'b0, res, lat, rs);
        vectors++; if (res !== a) begin miscompares++; $display("FAIL lsr0_res: got %h expected %h", res, a); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL lsr0_latency: got %0d expected 1", lat); end
        vectors++; if ({carry, overflow} !== {ref_carry, ref_overflow}) begin miscompares++; $display("FAIL shift_flags: got c=%b v=%b expected %b %b", carry, overflow, ref_carry, ref_overflow); end
    endtask

    task automatic test_random();
        logic [W-1:0] res; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp;
        logic [3:0] op; logic ic; logic sc; logic so; int lat; bit rs;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            ic = 1'($urandom_range(0, 1)); sc = 1'($urandom_range(0, 1)); so = 1'($urandom_range(0, 1));
            exp = model_result(op, a, b, ic);
            run_op(op, a, b, ic, sc, so, res, lat, rs);
            vectors++; if (res !== exp) begin miscompares++; $display("FAIL rand_res op=%0d a=%h b=%h: got %h expected %h", op, a, b, res, exp); end
            vectors++; if (lat !== model_latency(op, b)) begin miscompares++; $display("FAIL rand_latency op=%0d b=%h: got %0d expected %0d", op, b, lat, model_latency(op, b)); end
            vectors++; if ({carry, overflow} !== {ref_carry, ref_overflow}) begin miscompares++; $display("FAIL rand_flags op=%0d: got c=%b v=%b expected %b %b", op, carry, overflow, ref_carry, ref_overflow); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; logic [3:0] op;
        logic [3:0] ops[5];
        ops[0] = OP_ADD; ops[1] = OP_ADD; ops[2] = OP_XOR; ops[3] = OP_AND; ops[4] = OP_NOP;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 4)];
            a = $urandom; b = $urandom;
            // Chained add-with-carry: carry-in is the flag the previous op left behind.
            drive(op, a, b, ref_carry, 1'b1, 1'b1);
            in_valid = 1'b1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", i, in_ready); end
            exp_q.push_back(model_result(op, a, b, ref_carry));
            model_flags(op, a, b, ref_carry, 1'b1, 1'b1);
            step();
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = '0;
            vectors++; if (out_valid !== 1'b1 || result !== exp) begin miscompares++; $display("FAIL b2b_result cycle %0d: got v=%b %h expected v=1 %h", i, out_valid, result, exp); end
            vectors++; if ({carry, overflow} !== {ref_carry, ref_overflow}) begin miscompares++; $display("FAIL b2b_flags cycle %0d: got c=%b v=%b expected %b %b", i, carry, overflow, ref_carry, ref_overflow); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1; logic [W-1:0] b1; logic [W-1:0] a2; logic [W-1:0] b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        out_ready = 1'b0;
        drive(OP_XOR, a1, b1, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        drive(OP_AND, a2, b2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b1 || result !== (a1 ^ b1)) begin miscompares++; $display("FAIL bp_hold cycle %0d: got v=%b %h expected v=1 %h", i, out_valid, result, a1 ^ b1); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || result !== (a2 & b2)) begin miscompares++; $display("FAIL bp_new_result: got v=%b %h expected v=1 %h", out_valid, result, a2 & b2); end
        vectors++; if ({carry, overflow} !== {ref_carry, ref_overflow}) begin miscompares++; $display("FAIL bp_flags: got c=%b v=%b expected %b %b", carry, overflow, ref_carry, ref_overflow); end
        step();
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] res; int lat; bit rs; bit saw_valid;
        // Set carry so that clearing it by reset is observable.
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, res, lat, rs);
        drive(OP_LSL, 32'h1, 32'd20, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_shift_in_ready: got %b expected 0", in_ready); end
        step();
        ref_carry = 1'b0; ref_overflow = 1'b0;
        vectors++; if (out_valid !== 1'b0 || result !== '0) begin miscompares++; $display("FAIL rst_shift_out: got v=%b %h expected v=0 00000000", out_valid, result); end
        vectors++; if ({carry, overflow} !== 2'b00) begin miscompares++; $display("FAIL rst_shift_flags: got c=%b v=%b expected 0 0", carry, overflow); end
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_shift_ready_after: got %b expected 1", in_ready); end
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) saw_valid = 1'b1;
            step();
        end
        vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL rst_shift_no_result: got out_valid seen=%b expected 0", saw_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
